// File: rtl/core_prefetch_split_pkg.sv
// Shared types and helpers for the split-slot instruction prefetcher.
package core_prefetch_split_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_WAIT = 1'b1
    } req_state_e;

    // Halfword slot selector: the hi half issues first, then the lo half.
    function automatic logic [HALF_W-1:0] pick_half(input logic [WORD_W-1:0] word, input logic lo_sel);
        return lo_sel ? word[HALF_W-1:0] : word[WORD_W-1:HALF_W];
    endfunction

endpackage

// File: rtl/core_prefetch_fifo.sv
// Word FIFO of 2**ORDER entries with synchronous clear and same-cycle push/pop.
module core_prefetch_fifo #(
    parameter int ORDER = 2,
    parameter int W     = 62
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear_i,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [W-1:0]   wdata_i,
    output logic [W-1:0]   rdata_o,
    output logic [ORDER:0] count_o,
    output logic           empty_o
);
    localparam int DEPTH = 1 << ORDER;
    localparam logic [ORDER:0]   CNT_ZERO = {(ORDER+1){1'b0}};
    localparam logic [ORDER:0]   CNT_ONE  = {{ORDER{1'b0}}, 1'b1};
    localparam logic [ORDER:0]   CNT_FULL = {1'b1, {ORDER{1'b0}}};
    localparam logic [ORDER-1:0] PTR_ONE  = CNT_ONE[ORDER-1:0];

    logic [W-1:0]     mem_q [DEPTH];
    logic [ORDER-1:0] wr_q;
    logic [ORDER-1:0] rd_q;
    logic [ORDER:0]   cnt_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push_i && (cnt_q != CNT_FULL);
    assign do_pop_s  = pop_i && (cnt_q != CNT_ZERO);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_q  <= {ORDER{1'b0}};
            rd_q  <= {ORDER{1'b0}};
            cnt_q <= CNT_ZERO;
        end else begin
            if (do_push_s) wr_q <= wr_q + PTR_ONE;
            if (do_pop_s)  rd_q <= rd_q + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/core_prefetch_split.sv
// Instruction prefetcher: single-outstanding bus requester feeding a word FIFO,
// issuing whole words or hi/lo halfword slots to decode with redirect and stall handling.
module core_prefetch_split
    import core_prefetch_split_pkg::*;
#(
    parameter int ORDER  = 2,
    parameter int ADDR_W = 30,
    parameter int HALF   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch,
    input  logic [ADDR_W:0]   branch_target,
    output logic              fetch,
    output logic [ADDR_W-1:0] addr,
    input  logic              fetched,
    input  logic [31:0]       fetch_data,
    output logic [31:0]       insn,
    output logic [ADDR_W:0]   insn_pc,
    output logic              insn_valid,
    output logic              nop
);
    localparam int ENT_W = WORD_W + ADDR_W;
    localparam bit HALF_EN = HALF[0];
    localparam logic [ORDER:0]    DEPTH_C  = {1'b1, {ORDER{1'b0}}};
    localparam logic [ADDR_W-1:0] HEAD_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    req_state_e        state_q, state_d;
    logic              discard_q, discard_d;
    logic              fetch_q, fetch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic              half_q, half_d;
    logic [31:0]       insn_q, insn_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic              valid_q, valid_d;

    logic              redirect_s, push_s, pop_s, clear_s, empty_s;
    logic [ENT_W-1:0]  rdata_s;
    logic [ORDER:0]    count_s;
    logic [WORD_W-1:0] head_word_s;
    logic [ADDR_W-1:0] head_pc_s;

    assign redirect_s  = branch | flush;
    assign head_word_s = rdata_s[ENT_W-1:ADDR_W];
    assign head_pc_s   = rdata_s[ADDR_W-1:0];

    core_prefetch_fifo #(.ORDER(ORDER), .W(ENT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_s),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({fetch_data, addr_q}),
        .rdata_o (rdata_s),
        .count_o (count_s),
        .empty_o (empty_s)
    );

    // Request FSM: one outstanding beat; a redirect turns an in-flight beat stale.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        fetch_d   = 1'b0;
        addr_d    = addr_q;
        head_d    = head_q;
        push_s    = 1'b0;
        clear_s   = 1'b0;
        if (fetched) begin
            state_d   = REQ_IDLE;
            discard_d = 1'b0;
            push_s    = (state_q == REQ_WAIT) && !discard_q && !redirect_s;
        end else if (redirect_s && (state_q == REQ_WAIT)) begin
            discard_d = 1'b1;
        end else begin
            discard_d = discard_q;
        end
        // A stale beat still owed after reset may be retired in the same cycle a new request goes out.
        if (redirect_s) begin
            clear_s = 1'b1;
            if (branch) begin
                head_d = branch_target[ADDR_W:1];
            end else if (empty_s) begin
                head_d = head_q;
            end else begin
                head_d = head_pc_s;
            end
        end else if ((state_q == REQ_IDLE) && (!discard_q || fetched) && (count_s != DEPTH_C)) begin
            state_d = REQ_WAIT;
            fetch_d = 1'b1;
            addr_d  = head_q;
            head_d  = head_q + HEAD_ONE;
        end else begin
            fetch_d = 1'b0;
        end
    end

    // Output stage: next slot from the FIFO head, or a bubble.
    always_comb begin
        half_d  = half_q;
        insn_d  = insn_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        pop_s   = 1'b0;
        if (branch) begin
            valid_d = 1'b0;
            half_d  = HALF_EN & branch_target[0];
        end else if (flush) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (empty_s) begin
            valid_d = 1'b0;
        end else if (HALF_EN) begin
            valid_d = 1'b1;
            insn_d  = {16'h0000, pick_half(head_word_s, half_q)};
            pc_d    = {head_pc_s, half_q};
            half_d  = ~half_q;
            pop_s   = half_q;
        end else begin
            valid_d = 1'b1;
            insn_d  = head_word_s;
            pc_d    = {head_pc_s, 1'b0};
            pop_s   = 1'b1;
        end
    end

    // State registers; reset remembers an in-flight beat so its late data is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ_IDLE;
            discard_q <= ((state_q == REQ_WAIT) || discard_q) && !fetched;
            fetch_q   <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            head_q    <= {ADDR_W{1'b0}};
            half_q    <= 1'b0;
            insn_q    <= 32'h0000_0000;
            pc_q      <= {(ADDR_W+1){1'b0}};
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            fetch_q   <= fetch_d;
            addr_q    <= addr_d;
            head_q    <= head_d;
            half_q    <= half_d;
            insn_q    <= insn_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
        end
    end

    assign fetch      = fetch_q;
    assign addr       = addr_q;
    assign insn       = insn_q;
    assign insn_pc    = pc_q;
    assign insn_valid = valid_q;
    assign nop        = ~valid_q;

endmodule

// File: tb/tb_core_prefetch_split.sv
// Directed bench: halfword-slot and whole-word prefetchers behind one-cycle-latency bus models.
module tb_core_prefetch_split;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_h = 1'b0;
    logic        branch_w = 1'b0;
    logic [30:0] target_h = 31'h0;
    logic [30:0] target_w = 31'h0;
    logic        fetch_h, fetch_w;
    logic [29:0] addr_h, addr_w;
    logic        fetched_h = 1'b0;
    logic        fetched_w = 1'b0;
    logic [31:0] data_h = 32'h0;
    logic [31:0] data_w = 32'h0;
    logic [31:0] insn_h, insn_w;
    logic [30:0] pc_h, pc_w;
    logic        valid_h, valid_w, nop_h, nop_w;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_req;
    int n_vis;

    core_prefetch_split #(.ORDER(2), .ADDR_W(30), .HALF(1)) u_dut_h (
        .clk (clk), .rst (rst), .stall (stall), .flush (flush),
        .branch (branch_h), .branch_target (target_h),
        .fetch (fetch_h), .addr (addr_h), .fetched (fetched_h), .fetch_data (data_h),
        .insn (insn_h), .insn_pc (pc_h), .insn_valid (valid_h), .nop (nop_h)
    );

    core_prefetch_split #(.ORDER(2), .ADDR_W(30), .HALF(0)) u_dut_w (
        .clk (clk), .rst (rst), .stall (stall), .flush (flush),
        .branch (branch_w), .branch_target (target_w),
        .fetch (fetch_w), .addr (addr_w), .fetched (fetched_w), .fetch_data (data_w),
        .insn (insn_w), .insn_pc (pc_w), .insn_valid (valid_w), .nop (nop_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'd0)      return 32'hAAAA_BBBB;
        else if (a == 30'd1) return 32'hCCCC_DDDD;
        else                 return {4'h1, a[11:0], 4'h2, a[11:0]};
    endfunction

    // Bus slaves answer every request one cycle later.
    always @(posedge clk) begin
        fetched_h <= fetch_h;
        data_h    <= mem_word(addr_h);
        fetched_w <= fetch_w;
        data_w    <= mem_word(addr_w);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_insn(input bit w, input string tag, input logic [31:0] ei, input logic [30:0] ep);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (w ? valid_w : valid_h) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, 64'(got), 64'd1);
        check({tag, "_insn"}, 64'(w ? insn_w : insn_h), 64'(ei));
        check({tag, "_pc"}, 64'(w ? pc_w : pc_h), 64'(ep));
    endtask

    task automatic wait_fetch_h(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (fetch_h) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 64'(got), 64'd1);
    endtask

    initial begin
        step(); step(); step();
        check("rst_fetch", 64'(fetch_h), 64'd0);
        check("rst_addr", 64'(addr_h), 64'd0);
        check("rst_valid", 64'(valid_h), 64'd0);
        check("rst_nop", 64'(nop_h), 64'd1);
        check("rst_insn", 64'(insn_h), 64'd0);
        check("rst_pc", 64'(pc_h), 64'd0);
        check("rst_nop_w", 64'(nop_w), 64'd1);

        rst = 1'b0;
        step();
        check("first_req", 64'(fetch_h), 64'd1);
        check("first_addr", 64'(addr_h), 64'd0);

        // Halfword slots, hi before lo.
        next_insn(1'b0, "t1_s0", 32'h0000_AAAA, 31'h00);
        next_insn(1'b0, "t1_s1", 32'h0000_BBBB, 31'h01);
        next_insn(1'b0, "t1_s2", 32'h0000_CCCC, 31'h02);
        next_insn(1'b0, "t1_s3", 32'h0000_DDDD, 31'h03);

        // Branch to a lo-half target while a beat is in flight.
        wait_fetch_h("t2_req");
        branch_h = 1'b1;
        target_h = 31'h0B;
        step();
        branch_h = 1'b0;
        next_insn(1'b0, "t2_s0", 32'h0000_2005, 31'h0B);
        next_insn(1'b0, "t2_s1", 32'h0000_1006, 31'h0C);

        // Stall: FIFO fills with exactly four words, no instruction issued.
        stall    = 1'b1;
        branch_h = 1'b1;
        target_h = 31'h40;
        step();
        branch_h = 1'b0;
        check("t3_bubble", 64'(valid_h), 64'd0);
        n_req = 0;
        n_vis = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (fetch_h) n_req++;
            if (valid_h) n_vis++;
        end
        check("t3_reqs", 64'(n_req), 64'd4);
        check("t3_no_issue", 64'(n_vis), 64'd0);
        check("t3_fetch_idle", 64'(fetch_h), 64'd0);
        stall = 1'b0;
        next_insn(1'b0, "t3_s0", 32'h0000_1020, 31'h40);
        next_insn(1'b0, "t3_s1", 32'h0000_2020, 31'h41);
        next_insn(1'b0, "t3_s2", 32'h0000_1021, 31'h42);
        next_insn(1'b0, "t3_s3", 32'h0000_2021, 31'h43);

        // Branch and flush together: branch target wins.
        branch_h = 1'b1;
        flush    = 1'b1;
        target_h = 31'h20;
        step();
        branch_h = 1'b0;
        flush    = 1'b0;
        next_insn(1'b0, "t4_s0", 32'h0000_1010, 31'h20);
        next_insn(1'b0, "t4_s1", 32'h0000_2010, 31'h21);

        // Whole-word mode: last word address wraps to zero, pc bit0 stays clear.
        branch_w = 1'b1;
        target_w = 31'h7FFF_FFFF;
        step();
        branch_w = 1'b0;
        next_insn(1'b1, "t5_w0", 32'h1FFF_2FFF, 31'h7FFF_FFFE);
        next_insn(1'b1, "t5_w1", 32'hAAAA_BBBB, 31'h0);
        next_insn(1'b1, "t5_w2", 32'hCCCC_DDDD, 31'h2);

        // Reset with a beat in flight: late data dropped, restart at zero.
        wait_fetch_h("t6_req");
        rst = 1'b1;
        step();
        check("t6_rst_fetch", 64'(fetch_h), 64'd0);
        check("t6_rst_valid", 64'(valid_h), 64'd0);
        check("t6_rst_nop", 64'(nop_h), 64'd1);
        rst = 1'b0;
        step();
        check("t6_restart", 64'(fetch_h), 64'd1);
        check("t6_restart_addr", 64'(addr_h), 64'd0);
        next_insn(1'b0, "t6_s0", 32'h0000_AAAA, 31'h00);
        next_insn(1'b0, "t6_s1", 32'h0000_BBBB, 31'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
